// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA framebuffer scan-out path.
// Contents: 640x480@60 timing constants, counter/geometry widths, the
// per-pixel pipeline payload, and the scale-factor clamp.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = 800;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = 525;

    localparam int unsigned CNT_W   = 10;  // hcnt/vcnt width
    localparam int unsigned GEO_W   = 12;  // image size / offset width
    localparam int unsigned PIX_W   = 8;   // grayscale pixel width
    localparam int unsigned FATOR_W = 3;   // scale factor width

    // Per-pixel sideband carried alongside the RAM read; syncs are active-high here.
    typedef struct packed {
        logic             active;
        logic             hsync;
        logic             vsync;
        logic             win;
        logic [PIX_W-1:0] fill;    // in-window value when no RAM read happens
    } pix_stage_t;

    // Illegal scale factors (0, 5..7) fall back to 1:1.
    function automatic logic [FATOR_W-1:0] clamp_fator(input logic [FATOR_W-1:0] f);
        if (f == '0 || f > FATOR_W'(4)) begin
            return FATOR_W'(1);
        end
        return f;
    endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// Framebuffer RAM read port.
// master (scan-out): drives ram_rdaddr / ram_rden, receives ram_rddata.
// slave  (RAM):      returns ram_rddata one cycle after the address edge.
interface vga_fb_reader_if
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] ram_rdaddr;
    logic              ram_rden;
    logic [PIX_W-1:0]  ram_rddata;

    modport master (output ram_rdaddr, output ram_rden, input ram_rddata);
    modport slave  (input ram_rdaddr, input ram_rden, output ram_rddata);
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster counters and raw timing decode.
// Ports: clk, reset (async active-low); hcnt/vcnt counters; hsync_c/vsync_c
// (active-high sync decode), active_c (visible region), frame_end_c (last
// position of the frame), frame_start (registered, high while counters are
// at (0,0); never high in the first cycle after reset).
module vga_timing
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync_c,
    output logic             vsync_c,
    output logic             active_c,
    output logic             frame_end_c,
    output logic             frame_start
);

    logic line_end_c;

    assign line_end_c  = (hcnt == CNT_W'(H_TOTAL - 1));
    assign frame_end_c = line_end_c && (vcnt == CNT_W'(V_TOTAL - 1));

    assign hsync_c  = (hcnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                      (hcnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_c  = (vcnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                      (vcnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    assign active_c = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));

    // Raster counters; frame_start is registered on the wrap edge so it lines up with (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            if (line_end_c) begin
                hcnt <= '0;
                vcnt <= frame_end_c ? '0 : vcnt + CNT_W'(1);
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end
            frame_start <= frame_end_c;
        end
    end

endmodule

// File: rtl/vga_fb_reader.sv
// VGA scan-out of a scaled grayscale framebuffer, centred on a 640x480 screen.
// Ports: clk, reset (async active-low); fator (scale 1..4), frame_ready
// (image complete); ram (framebuffer read port, master side); vga_r/g/b,
// hsync_n, vsync_n, blank_n (all 3 cycles behind the counters); frame_start.
// Build option: VGA_TESTPATTERN_EN shows a horizontal ramp in the window while
// the image is not ready; otherwise the window is black until ready.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned ADDR_W = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FATOR_W-1:0] fator,
    input  logic               frame_ready,
    vga_fb_reader_if.master    ram,
    output logic [PIX_W-1:0]   vga_r,
    output logic [PIX_W-1:0]   vga_g,
    output logic [PIX_W-1:0]   vga_b,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               blank_n,
    output logic               frame_start
);

    localparam logic [GEO_W-1:0] X0_RST   = GEO_W'((H_ACTIVE - SRC_W) / 2);
    localparam logic [GEO_W-1:0] Y0_RST   = GEO_W'((V_ACTIVE - SRC_H) / 2);
    localparam logic [GEO_W-1:0] XEND_RST = GEO_W'((H_ACTIVE - SRC_W) / 2 + SRC_W);
    localparam logic [GEO_W-1:0] YEND_RST = GEO_W'((V_ACTIVE - SRC_H) / 2 + SRC_H);

    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   vcnt;
    logic               hsync_c;
    logic               vsync_c;
    logic               active_c;
    logic               frame_end_c;

    logic [FATOR_W-1:0] f_next_c;
    logic [GEO_W-1:0]   img_w_next_c;
    logic [GEO_W-1:0]   img_h_next_c;
    logic [GEO_W-1:0]   x0_next_c;
    logic [GEO_W-1:0]   y0_next_c;

    logic               rdy;
    logic [GEO_W-1:0]   x0;
    logic [GEO_W-1:0]   y0;
    logic [GEO_W-1:0]   x_end;
    logic [GEO_W-1:0]   y_end;

    logic               win_c;
    logic               origin_c;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [ADDR_W-1:0]  addr_cur_c;
    logic [PIX_W-1:0]   fill_c;

    pix_stage_t         s1_next_c;
    pix_stage_t         s1;
    pix_stage_t         s2;
    logic               rd2;
    logic [PIX_W-1:0]   pix_c;

    vga_timing u_timing (
        .clk         (clk),
        .reset       (reset),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hsync_c     (hsync_c),
        .vsync_c     (vsync_c),
        .active_c    (active_c),
        .frame_end_c (frame_end_c),
        .frame_start (frame_start)
    );

    // Geometry for the frame about to start, from the clamped scale factor.
    assign f_next_c     = clamp_fator(fator);
    assign img_w_next_c = GEO_W'(SRC_W * 32'(f_next_c));
    assign img_h_next_c = GEO_W'(SRC_H * 32'(f_next_c));
    assign x0_next_c    = (GEO_W'(H_ACTIVE) - img_w_next_c) >> 1;
    assign y0_next_c    = (GEO_W'(V_ACTIVE) - img_h_next_c) >> 1;

    // Frame latch on the wrap edge, so the new values are live from (0,0) on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy   <= 1'b0;
            x0    <= X0_RST;
            y0    <= Y0_RST;
            x_end <= XEND_RST;
            y_end <= YEND_RST;
        end else if (frame_end_c) begin
            rdy   <= frame_ready;
            x0    <= x0_next_c;
            y0    <= y0_next_c;
            x_end <= x0_next_c + img_w_next_c;
            y_end <= y0_next_c + img_h_next_c;
        end
    end

    assign win_c    = (GEO_W'(hcnt) >= x0) && (GEO_W'(hcnt) < x_end) &&
                      (GEO_W'(vcnt) >= y0) && (GEO_W'(vcnt) < y_end);
    assign origin_c = (hcnt == '0) && (vcnt == '0);

    // The window may include (0,0) at 4x, so the clear is folded into the current value.
    assign addr_cur_c = origin_c ? '0 : addr_cnt;

`ifdef VGA_TESTPATTERN_EN
    assign fill_c = PIX_W'(GEO_W'(hcnt) - x0);
`else
    assign fill_c = '0;
`endif

    always_comb begin
        s1_next_c        = '0;
        s1_next_c.active = active_c;
        s1_next_c.hsync  = hsync_c;
        s1_next_c.vsync  = vsync_c;
        s1_next_c.win    = win_c;
        s1_next_c.fill   = fill_c;
    end

    // Stage 1: read request plus sideband for the same pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt       <= '0;
            ram.ram_rdaddr <= '0;
            ram.ram_rden   <= 1'b0;
            s1             <= '0;
        end else begin
            addr_cnt     <= win_c ? addr_cur_c + ADDR_W'(1) : addr_cur_c;
            ram.ram_rden <= win_c && rdy;
            if (win_c && rdy) begin
                ram.ram_rdaddr <= addr_cur_c;
            end
            s1 <= s1_next_c;
        end
    end

    // Stage 2: sideband waits while the RAM returns data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2  <= '0;
            rd2 <= 1'b0;
        end else begin
            s2  <= s1;
            rd2 <= ram.ram_rden;
        end
    end

    always_comb begin
        pix_c = '0;
        if (rd2) begin
            pix_c = ram.ram_rddata;
        end else if (s2.win) begin
            pix_c = s2.fill;
        end
    end

    // Stage 3: DAC outputs, syncs delayed identically to the pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            blank_n <= 1'b0;
        end else begin
            vga_r   <= pix_c;
            vga_g   <= pix_c;
            vga_b   <= pix_c;
            hsync_n <= ~s2.hsync;
            vsync_n <= ~s2.vsync;
            blank_n <= s2.active;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench for vga_fb_reader: a raster/frame model predicts every
// cycle's RAM request and the pixel/sync/blank word three cycles later.
module tb_vga_fb_reader;
    import vga_pkg::*;

    localparam int unsigned SRC_W     = 160;
    localparam int unsigned SRC_H     = 120;
    localparam int unsigned ADDR_W    = 19;
    localparam int unsigned FRAME_CYC = H_TOTAL * V_TOTAL;
    localparam logic [31:0] RST_PIX   = 32'({24'h000000, 1'b1, 1'b1, 1'b0});

    logic       clk;
    logic       reset;
    logic [2:0] fator;
    logic       frame_ready;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic       frame_start;

    vga_fb_reader_if #(.ADDR_W(ADDR_W)) ram ();

    vga_fb_reader #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .fator       (fator),
        .frame_ready (frame_ready),
        .ram         (ram),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .blank_n     (blank_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // RAM model: data = addr[7:0]; garbage when not enabled.
    always @(posedge clk) begin
        ram.ram_rddata <= ram.ram_rden ? ram.ram_rdaddr[7:0] : 8'($urandom);
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mh, mv;
    int          m_w, m_h, m_x0, m_y0;
    bit          m_rdy;
    bit          m_first;
    bit          checking = 1'b0;
    int          reads;
    int          last_addr;
    logic [31:0] pixq[$];
    logic [31:0] ramq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    task automatic latch_frame(input logic [2:0] f_in, input bit r_in);
        int f;
        f     = (f_in == 3'd0 || f_in > 3'd4) ? 1 : int'(f_in);
        m_w   = int'(SRC_W) * f;
        m_h   = int'(SRC_H) * f;
        m_x0  = (int'(H_ACTIVE) - m_w) / 2;
        m_y0  = (int'(V_ACTIVE) - m_h) / 2;
        m_rdy = r_in;
    endtask

    task automatic model_restart();
        mh        = 0;
        mv        = 0;
        m_first   = 1'b1;
        reads     = 0;
        last_addr = 0;
        latch_frame(3'd1, 1'b0);
        pixq.delete();
        ramq.delete();
        repeat (3) pixq.push_back(RST_PIX);
        ramq.push_back(32'd0);
    endtask

    // Raster/frame model advances on the same edges as the DUT.
    always @(posedge clk) begin
        if (reset && checking) begin
            m_first = 1'b0;
            if (mh == int'(H_TOTAL) - 1) begin
                mh = 0;
                if (mv == int'(V_TOTAL) - 1) begin
                    mv = 0;
                    check("reads_per_frame", 32'(reads), m_rdy ? 32'(m_w * m_h) : 32'd0);
                    reads = 0;
                    latch_frame(fator, frame_ready);
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
    end

    // Compare against earlier predictions, then predict for the current counter cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        bit          win, rd, hs, vs, act;
        int          a;
        logic [7:0]  pix, fill;
        if (reset && checking) begin
            e = ramq.pop_front();
            check("ram_rden", 32'(ram.ram_rden), 32'(e[ADDR_W]));
            check("ram_rdaddr", 32'(ram.ram_rdaddr), 32'(e[ADDR_W-1:0]));
            if (ram.ram_rden) reads++;
            e = pixq.pop_front();
            check("pixel_sync_blank", 32'({vga_r, vga_g, vga_b, hsync_n, vsync_n, blank_n}), e);
            check("frame_start", 32'(frame_start), 32'(mh == 0 && mv == 0 && !m_first));

            win = (mh >= m_x0) && (mh < m_x0 + m_w) && (mv >= m_y0) && (mv < m_y0 + m_h);
            rd  = win && m_rdy;
            a   = (mv - m_y0) * m_w + (mh - m_x0);
            if (rd) last_addr = a;
            ramq.push_back(32'({rd, ADDR_W'(last_addr)}));
`ifdef VGA_TESTPATTERN_EN
            fill = 8'(mh - m_x0);
`else
            fill = 8'h00;
`endif
            pix = rd ? 8'(a) : (win ? fill : 8'h00);
            hs  = !(mh >= 656 && mh < 752);
            vs  = !(mv >= 490 && mv < 492);
            act = (mh < 640) && (mv < 480);
            pixq.push_back(32'({pix, pix, pix, hs, vs, act}));
        end
    end

    task automatic release_reset();
        @(posedge clk);
        #5;
        model_restart();
        checking = 1'b1;
        reset    = 1'b1;
    endtask

    task automatic wait_pos(input int h, input int v, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(mh == h && mv == v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_pos_reached", 32'(mh == h && mv == v), 32'd1);
        #5;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel"}, 32'({vga_r, vga_g, vga_b, hsync_n, vsync_n, blank_n}), RST_PIX);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_rden"}, 32'(ram.ram_rden), 32'd0);
        check({tag, "_rdaddr"}, 32'(ram.ram_rdaddr), 32'd0);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        fator       = 3'd1;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        release_reset();

        // Reset pulse mid-frame: outputs clear without waiting for an edge.
        wait_pos(300, 200, int'(FRAME_CYC));
        checking = 1'b0;
        reset    = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        release_reset();

        // Frame A: reset geometry, not ready. Next frame: 4x, ready.
        wait_pos(0, 100, int'(FRAME_CYC));
        fator       = 3'd4;
        frame_ready = 1'b1;
        wait_pos(0, 0, int'(FRAME_CYC));

        // Frame B: 4x full screen; switch to 2x mid-frame.
        wait_pos(0, 240, int'(FRAME_CYC));
        fator = 3'd2;
        wait_pos(0, 0, int'(FRAME_CYC));

        // Frame C: 2x; 2 -> 3 mid-frame must not disturb this frame.
        wait_pos(0, 200, int'(FRAME_CYC));
        fator = 3'd3;
        wait_pos(0, 0, int'(FRAME_CYC));

        // Frame D: 3x; illegal 7 requested for the next frame.
        wait_pos(0, 300, int'(FRAME_CYC));
        fator = 3'd7;
        wait_pos(0, 0, int'(FRAME_CYC));

        // Frame E: 1x ready; 0 requested and ready drops mid-frame.
        wait_pos(0, 250, int'(FRAME_CYC));
        fator       = 3'd0;
        frame_ready = 1'b0;
        wait_pos(0, 0, int'(FRAME_CYC));

        // Frame F: not ready, no reads.
        wait_pos(0, 4, int'(FRAME_CYC));
        checking = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
